// File: rtl/mbox_ebox_resp.sv
// mbox_ebox_resp: MBOX-side responder for EBOX memory requests.
// Each accepted request runs one backing-memory access, or a read followed
// by a write. The EBOX gets a single-cycle response pulse with the read data.
// An access that sees no memAck within TIMEOUT cycles is aborted as
// non-existent memory.
// Optional feature: define MBOX_RESP_PARITY_EN for odd parity on the memory
// data path. Without it memWPar and mbParErr stay 0 and memRPar is ignored.
module mbox_ebox_resp #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         RESET_N,
  input  logic         EBOX_REQ,
  input  logic [13:35] EBOX_VMA,
  input  logic         eboxRead,
  input  logic         eboxWrite,
  input  logic         eboxPSE,
  input  logic [0:35]  cacheDataWrite,
  output logic         mboxRespIn,
  output logic [0:35]  cacheDataRead,
  output logic         nxmErr,
  output logic         mbParErr,
  output logic [13:35] memAddr,
  output logic         memRead,
  output logic         memWrite,
  output logic [0:35]  memWData,
  output logic         memWPar,
  input  logic [0:35]  memRData,
  input  logic         memRPar,
  input  logic         memAck
);

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, PAUSE} state_e;

  state_e       state_q, state_d;
  logic [13:35] addr_q, addr_d;
  logic [0:35]  wdata_q, wdata_d;
  logic [0:35]  rdata_q, rdata_d;
  logic         wr_q, wr_d;
  logic         pse_q, pse_d;
  logic         pause_pend_q, pause_pend_d;
  logic         nxm_q, nxm_d;
  logic         perr_q, perr_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         rd_par_bad;
  logic         timeout_hit;

`ifdef MBOX_RESP_PARITY_EN
  // A good read word carries an odd number of ones across data and parity.
  assign rd_par_bad = ~(^{memRData, memRPar});
`else
  // Parity checking is absent; memRPar stays wired but has no effect.
  assign rd_par_bad = 1'b0 & memRPar;
`endif

  // The abort fires on the edge where the wait counter would reach TIMEOUT.
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Next-state logic for the request sequencer and its latched request context.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    wr_d         = wr_q;
    pse_d        = pse_q;
    pause_pend_d = pause_pend_q;
    nxm_d        = nxm_q;
    perr_d       = perr_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (EBOX_REQ) begin
          addr_d       = EBOX_VMA;
          wdata_d      = cacheDataWrite;
          wr_d         = eboxWrite;
          pse_d        = eboxPSE;
          pause_pend_d = 1'b0;
          nxm_d        = 1'b0;
          perr_d       = 1'b0;
          cnt_d        = 8'd0;
          if (eboxRead)       state_d = RD;
          else if (eboxWrite) state_d = WR;
          else                state_d = RESP;
        end
      end
      RD: begin
        if (memAck) begin
          rdata_d = memRData;
          perr_d  = rd_par_bad;
          if (wr_q && !pse_q) begin
            state_d = WR;
            cnt_d   = 8'd0;
          end else begin
            state_d      = RESP;
            pause_pend_d = wr_q && pse_q;
          end
        end else if (timeout_hit) begin
          state_d      = RESP;
          rdata_d      = '0;
          nxm_d        = 1'b1;
          pause_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR: begin
        if (memAck) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d      = RESP;
          rdata_d      = '0;
          nxm_d        = 1'b1;
          pause_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d      = pause_pend_q ? PAUSE : IDLE;
        pause_pend_d = 1'b0;
      end
      PAUSE: begin
        if (EBOX_REQ) begin
          nxm_d  = 1'b0;
          perr_d = 1'b0;
          if (eboxWrite) begin
            wdata_d = cacheDataWrite;
            cnt_d   = 8'd0;
            state_d = WR;
          end else begin
            pause_pend_d = 1'b1;
            state_d      = RESP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and context registers; reset drops any in-flight access immediately.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wr_q         <= 1'b0;
      pse_q        <= 1'b0;
      pause_pend_q <= 1'b0;
      nxm_q        <= 1'b0;
      perr_q       <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      wr_q         <= wr_d;
      pse_q        <= pse_d;
      pause_pend_q <= pause_pend_d;
      nxm_q        <= nxm_d;
      perr_q       <= perr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign memRead       = (state_q == RD);
  assign memWrite      = (state_q == WR);
  assign memAddr       = (memRead || memWrite) ? addr_q : '0;
  assign memWData      = memWrite ? wdata_q : '0;
  assign mboxRespIn    = (state_q == RESP);
  assign nxmErr        = mboxRespIn && nxm_q;
  assign mbParErr      = mboxRespIn && perr_q;
  assign cacheDataRead = rdata_q;

`ifdef MBOX_RESP_PARITY_EN
  assign memWPar = memWrite && ~(^wdata_q);
`else
  assign memWPar = 1'b0;
`endif

endmodule

// File: tb/tb_mbox_ebox_resp.sv
// Directed testbench for mbox_ebox_resp with hand-computed expectations.
module tb_mbox_ebox_resp;

  localparam int TO = 63;

  logic         clk = 1'b0;
  logic         RESET_N;
  logic         EBOX_REQ;
  logic [13:35] EBOX_VMA;
  logic         eboxRead, eboxWrite, eboxPSE;
  logic [0:35]  cacheDataWrite;
  logic         mboxRespIn;
  logic [0:35]  cacheDataRead;
  logic         nxmErr, mbParErr;
  logic [13:35] memAddr;
  logic         memRead, memWrite;
  logic [0:35]  memWData;
  logic         memWPar;
  logic [0:35]  memRData;
  logic         memRPar;
  logic         memAck;

  int checks = 0;
  int errors = 0;

  mbox_ebox_resp #(.TIMEOUT(TO)) dut (
    .clk(clk), .RESET_N(RESET_N), .EBOX_REQ(EBOX_REQ), .EBOX_VMA(EBOX_VMA),
    .eboxRead(eboxRead), .eboxWrite(eboxWrite), .eboxPSE(eboxPSE),
    .cacheDataWrite(cacheDataWrite), .mboxRespIn(mboxRespIn),
    .cacheDataRead(cacheDataRead), .nxmErr(nxmErr), .mbParErr(mbParErr),
    .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
    .memWData(memWData), .memWPar(memWPar), .memRData(memRData),
    .memRPar(memRPar), .memAck(memAck)
  );

  always #5 clk = ~clk;

  // Odd write parity when the parity feature is built in, else constant 0.
  function automatic logic exp_wpar(input logic [0:35] d);
`ifdef MBOX_RESP_PARITY_EN
    return ~(^d);
`else
    return 1'b0;
`endif
  endfunction

  // Expected read parity error for a given data/parity pair.
  function automatic logic exp_perr(input logic [0:35] d, input logic p);
`ifdef MBOX_RESP_PARITY_EN
    return ~(^{d, p});
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    EBOX_REQ  = 1'b0;
    eboxRead  = 1'b0;
    eboxWrite = 1'b0;
    eboxPSE   = 1'b0;
    memAck    = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr, input logic pse,
                     input logic [13:35] vma, input logic [0:35] d);
    EBOX_REQ = 1'b1; eboxRead = rd; eboxWrite = wr; eboxPSE = pse;
    EBOX_VMA = vma; cacheDataWrite = d;
    tick();
    idle_inputs();
  endtask

  task automatic ack(input logic [0:35] d, input logic p);
    memAck = 1'b1; memRData = d; memRPar = p;
    tick();
    memAck = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    idle_inputs();
    EBOX_VMA = '0; cacheDataWrite = '0; memRData = '0; memRPar = 1'b0;
    tick(); tick();
    checks++;
    if ({mboxRespIn, nxmErr, mbParErr, memRead, memWrite, memWPar} !== 6'b0 ||
        cacheDataRead !== 36'o0 || memAddr !== 23'o0 || memWData !== 36'o0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got resp=%0b rd=%0b wr=%0b addr=%o data=%o want all 0",
               mboxRespIn, memRead, memWrite, memAddr, cacheDataRead);
    end
    @(negedge clk) RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_read();
    req(1'b1, 1'b0, 1'b0, 23'o1234, 36'o0);
    checks++;
    if (memRead !== 1'b1 || memAddr !== 23'o1234 || mboxRespIn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_c1 got rd=%0b addr=%o resp=%0b want 1 1234 0", memRead, memAddr, mboxRespIn);
    end
    tick();
    checks++;
    if (memRead !== 1'b1) begin
      errors++; $display("[TB] FAIL read_c2 got rd=%0b want 1", memRead);
    end
    ack(36'o123456701234, 1'b0);
    checks++;
    if (mboxRespIn !== 1'b1 || memRead !== 1'b0 || cacheDataRead !== 36'o123456701234 || nxmErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_resp got resp=%0b rd=%0b data=%o nxm=%0b want 1 0 123456701234 0",
               mboxRespIn, memRead, cacheDataRead, nxmErr);
    end
    checks++;
    if (mbParErr !== exp_perr(36'o123456701234, 1'b0)) begin
      errors++; $display("[TB] FAIL read_perr got %0b want %0b", mbParErr, exp_perr(36'o123456701234, 1'b0));
    end
    tick();
    checks++;
    if (mboxRespIn !== 1'b0 || cacheDataRead !== 36'o123456701234) begin
      errors++; $display("[TB] FAIL read_hold got resp=%0b data=%o want 0 123456701234", mboxRespIn, cacheDataRead);
    end
  endtask

  task automatic test_write();
    req(1'b0, 1'b1, 1'b0, 23'o777, 36'o525252525252);
    checks++;
    if (memWrite !== 1'b1 || memRead !== 1'b0 || memAddr !== 23'o777 || memWData !== 36'o525252525252 ||
        memWPar !== exp_wpar(36'o525252525252)) begin
      errors++;
      $display("[TB] FAIL write_c1 got wr=%0b rd=%0b addr=%o wdata=%o par=%0b want 1 0 777 525252525252 %0b",
               memWrite, memRead, memAddr, memWData, memWPar, exp_wpar(36'o525252525252));
    end
    tick();
    ack(36'o0, 1'b0);
    checks++;
    if (mboxRespIn !== 1'b1 || memWrite !== 1'b0 || cacheDataRead !== 36'o123456701234 || nxmErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_resp got resp=%0b wr=%0b data=%o nxm=%0b want 1 0 123456701234 0",
               mboxRespIn, memWrite, cacheDataRead, nxmErr);
    end
    tick();
    checks++;
    if (mboxRespIn !== 1'b0) begin
      errors++; $display("[TB] FAIL write_single_pulse got resp=%0b want 0", mboxRespIn);
    end
  endtask

  task automatic test_noop();
    req(1'b0, 1'b0, 1'b0, 23'o5, 36'o0);
    checks++;
    if (mboxRespIn !== 1'b1 || memRead !== 1'b0 || memWrite !== 1'b0) begin
      errors++; $display("[TB] FAIL noop_resp got resp=%0b rd=%0b wr=%0b want 1 0 0", mboxRespIn, memRead, memWrite);
    end
    tick();
  endtask

  task automatic test_pse();
    req(1'b1, 1'b1, 1'b1, 23'o40, 36'o0);
    checks++;
    if (memRead !== 1'b1 || memWrite !== 1'b0 || memAddr !== 23'o40) begin
      errors++; $display("[TB] FAIL pse_read got rd=%0b wr=%0b addr=%o want 1 0 40", memRead, memWrite, memAddr);
    end
    ack(36'o5, 1'b0);
    checks++;
    if (mboxRespIn !== 1'b1 || cacheDataRead !== 36'o5) begin
      errors++; $display("[TB] FAIL pse_read_resp got resp=%0b data=%o want 1 5", mboxRespIn, cacheDataRead);
    end
    tick(); tick();
    checks++;
    if (mboxRespIn !== 1'b0 || memRead !== 1'b0 || memWrite !== 1'b0) begin
      errors++; $display("[TB] FAIL pse_pause_idle got resp=%0b rd=%0b wr=%0b want 0 0 0", mboxRespIn, memRead, memWrite);
    end
    // A read request while paused is a no-op answered in the next cycle.
    req(1'b1, 1'b0, 1'b0, 23'o1, 36'o0);
    checks++;
    if (mboxRespIn !== 1'b1 || memRead !== 1'b0) begin
      errors++; $display("[TB] FAIL pse_pause_noop got resp=%0b rd=%0b want 1 0", mboxRespIn, memRead);
    end
    tick();
    req(1'b0, 1'b1, 1'b0, 23'o1177, 36'o6);
    checks++;
    if (memWrite !== 1'b1 || memAddr !== 23'o40 || memWData !== 36'o6) begin
      errors++; $display("[TB] FAIL pse_write got wr=%0b addr=%o wdata=%o want 1 40 6", memWrite, memAddr, memWData);
    end
    ack(36'o0, 1'b0);
    checks++;
    if (mboxRespIn !== 1'b1 || memWrite !== 1'b0) begin
      errors++; $display("[TB] FAIL pse_write_resp got resp=%0b wr=%0b want 1 0", mboxRespIn, memWrite);
    end
    tick();
    // Back in IDLE, so a read request now starts a real read.
    req(1'b1, 1'b0, 1'b0, 23'o2, 36'o0);
    checks++;
    if (memRead !== 1'b1 || memAddr !== 23'o2) begin
      errors++; $display("[TB] FAIL pse_back_idle got rd=%0b addr=%o want 1 2", memRead, memAddr);
    end
    ack(36'o0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    req(1'b1, 1'b1, 1'b0, 23'o100, 36'o7);
    ack(36'o11, 1'b0);
    checks++;
    if (memWrite !== 1'b1 || memRead !== 1'b0 || mboxRespIn !== 1'b0 || memAddr !== 23'o100 ||
        memWData !== 36'o7 || cacheDataRead !== 36'o11) begin
      errors++;
      $display("[TB] FAIL rmw_write got wr=%0b rd=%0b resp=%0b addr=%o wdata=%o data=%o want 1 0 0 100 7 11",
               memWrite, memRead, mboxRespIn, memAddr, memWData, cacheDataRead);
    end
    ack(36'o0, 1'b0);
    checks++;
    if (mboxRespIn !== 1'b1 || memWrite !== 1'b0) begin
      errors++; $display("[TB] FAIL rmw_resp got resp=%0b wr=%0b want 1 0", mboxRespIn, memWrite);
    end
    tick();
  endtask

  task automatic test_timeout();
    req(1'b1, 1'b0, 1'b0, 23'o3, 36'o0);
    repeat (TO - 1) tick();
    checks++;
    if (memRead !== 1'b1 || mboxRespIn !== 1'b0) begin
      errors++; $display("[TB] FAIL to_last_cycle got rd=%0b resp=%0b want 1 0", memRead, mboxRespIn);
    end
    tick();
    checks++;
    if (mboxRespIn !== 1'b1 || nxmErr !== 1'b1 || cacheDataRead !== 36'o0 || memRead !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_resp got resp=%0b nxm=%0b data=%o rd=%0b want 1 1 0 0",
               mboxRespIn, nxmErr, cacheDataRead, memRead);
    end
    ack(36'o77, 1'b0);
    tick();
    checks++;
    if (mboxRespIn !== 1'b0 || memRead !== 1'b0 || cacheDataRead !== 36'o0) begin
      errors++; $display("[TB] FAIL to_late_ack got resp=%0b rd=%0b data=%o want 0 0 0", mboxRespIn, memRead, cacheDataRead);
    end
    // Ack on the last allowed cycle still succeeds.
    req(1'b1, 1'b0, 1'b0, 23'o4, 36'o0);
    repeat (TO - 1) tick();
    ack(36'o4321, 1'b0);
    checks++;
    if (mboxRespIn !== 1'b1 || nxmErr !== 1'b0 || cacheDataRead !== 36'o4321) begin
      errors++; $display("[TB] FAIL to_ack_wins got resp=%0b nxm=%0b data=%o want 1 0 4321", mboxRespIn, nxmErr, cacheDataRead);
    end
    tick();
    // A timed-out PSE read must not leave the sequencer paused.
    req(1'b1, 1'b1, 1'b1, 23'o6, 36'o0);
    repeat (TO) tick();
    checks++;
    if (mboxRespIn !== 1'b1 || nxmErr !== 1'b1) begin
      errors++; $display("[TB] FAIL to_pse_resp got resp=%0b nxm=%0b want 1 1", mboxRespIn, nxmErr);
    end
    tick();
    req(1'b1, 1'b0, 1'b0, 23'o7, 36'o0);
    checks++;
    if (memRead !== 1'b1 || mboxRespIn !== 1'b0) begin
      errors++; $display("[TB] FAIL to_pse_cancel got rd=%0b resp=%0b want 1 0", memRead, mboxRespIn);
    end
    ack(36'o0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_read();
    req(1'b1, 1'b0, 1'b0, 23'o10, 36'o0);
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (memRead !== 1'b0 || mboxRespIn !== 1'b0 || memAddr !== 23'o0) begin
      errors++; $display("[TB] FAIL rst_mid_rd got rd=%0b resp=%0b addr=%o want 0 0 0", memRead, mboxRespIn, memAddr);
    end
    tick();
    @(negedge clk) RESET_N = 1'b1;
    tick();
    checks++;
    if (mboxRespIn !== 1'b0 || memRead !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_no_resp got resp=%0b rd=%0b want 0 0", mboxRespIn, memRead);
    end
    req(1'b1, 1'b0, 1'b0, 23'o11, 36'o0);
    ack(36'o2222, 1'b0);
    checks++;
    if (mboxRespIn !== 1'b1 || cacheDataRead !== 36'o2222) begin
      errors++; $display("[TB] FAIL rst_after got resp=%0b data=%o want 1 2222", mboxRespIn, cacheDataRead);
    end
    tick();
  endtask

  task automatic test_parity();
    req(1'b1, 1'b0, 1'b0, 23'o12, 36'o0);
    ack(36'o0, 1'b0);
    checks++;
    if (mboxRespIn !== 1'b1 || mbParErr !== exp_perr(36'o0, 1'b0) || cacheDataRead !== 36'o0) begin
      errors++; $display("[TB] FAIL par_bad got perr=%0b data=%o want %0b 0", mbParErr, cacheDataRead, exp_perr(36'o0, 1'b0));
    end
    tick();
    req(1'b1, 1'b0, 1'b0, 23'o12, 36'o0);
    ack(36'o0, 1'b1);
    checks++;
    if (mboxRespIn !== 1'b1 || mbParErr !== 1'b0) begin
      errors++; $display("[TB] FAIL par_good got perr=%0b want 0", mbParErr);
    end
    tick();
    req(1'b0, 1'b1, 1'b0, 23'o13, 36'o0);
    checks++;
    if (memWrite !== 1'b1 || memWPar !== exp_wpar(36'o0)) begin
      errors++; $display("[TB] FAIL par_wpar got wr=%0b par=%0b want 1 %0b", memWrite, memWPar, exp_wpar(36'o0));
    end
    ack(36'o0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_noop();
    test_pse();
    test_back_to_back();
    test_timeout();
    test_reset_mid_read();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
